instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Encoder/writer counterpart to the opcode-decoding control unit: accepts symbolic instruction
//  requests (op, rd, rs1, rs2, imm) and encodes them into 32-bit RV32I words (ADD, LW, SW, BEQ, JAL).
//  Buffers them in a small FIFO and streams them into instruction memory at consecutive word addresses.
//  Used by the bench/boot path to load programs that the control unit later decodes.
// PARAMETERS
//  DEPTH      4   FIFO entries (power of 2, >=2)
//  ADDR_W     10  imem word-address width
//  BASE_ADDR  0   first word address written after start
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous reset, active low
//  start      in   1       pulse: open a load session
//  finish     in   1       pulse: close the session after the FIFO drains
//  req_valid  in   1       request valid
//  req_ready  out  1       request accepted when valid&&ready
//  req_op     in   3       0=ADD 1=LW 2=SW 3=BEQ 4=JAL; 5..7 illegal
//  req_rd     in   5       destination register
//  req_rs1    in   5       source register 1
//  req_rs2    in   5       source register 2
//  req_imm    in   21      signed immediate (byte offset for BEQ/JAL)
//  imem_we    out  1       write strobe
//  imem_ready in   1       imem accepts the write when imem_we&&imem_ready
//  imem_addr  out  ADDR_W  word address
//  imem_wdata out  32      encoded instruction
//  busy       out  1       state != IDLE
//  done       out  1       one-cycle pulse when DRAIN completes
//  err_op     out  1       sticky: an illegal req_op was accepted; cleared by start
//  addr_full  out  1       sticky: last address written; cleared by start
// BEHAVIOUR
//  - Reset values: req_ready, imem_we, busy, done, err_op and addr_full are 0; imem_addr=BASE_ADDR;
//    imem_wdata=0; FIFO empty; state=IDLE.
//  - FSM states: IDLE, LOAD, DRAIN, FULL.
//    IDLE -start-> LOAD. LOAD -finish-> DRAIN. DRAIN -FIFO empty-> IDLE, with done=1 for 1 cycle.
//    Any state -write to address 2^ADDR_W-1-> FULL. FULL -start-> LOAD; otherwise FULL holds.
//  - start in any state: flushes the FIFO, sets imem_addr=BASE_ADDR, clears err_op and addr_full,
//    enters LOAD. start has priority over finish and over a same-cycle push.
//  - Push rule: req_ready = (state==LOAD) && (count<DEPTH).
//    Encoding is combinational at push time; the FIFO stores the 32-bit word.
//  - Illegal op (5..7): the handshake completes, nothing is enqueued, err_op sets.
//  - Encodings:
//    ADD  {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011}
//    LW   {imm[11:0], rs1, 3'b010, rd, 7'b0000011}
//    SW   {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011}
//    BEQ  {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011}
//    JAL  {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111}
//    Out-of-range immediates are silently truncated; imm[0] is dropped for BEQ/JAL.
//  - Drain rule: imem_we = !empty && state in {LOAD, DRAIN}.
//    imem_wdata = FIFO head, held stable while imem_we && !imem_ready.
//    Each accepted write pops the head and increments imem_addr by 1.
//  - Wrap: a write to address 2^ADDR_W-1 sets addr_full and enters FULL. imem_addr does not wrap.
//    In FULL, imem_we=0, req_ready=0, and queued words are retained.
//  - Push and pop in the same cycle: count unchanged; a full FIFO may accept a push only on a pop cycle.
//    Latency: a push into an empty FIFO appears on imem_we on the next cycle.
//  - finish while in IDLE or FULL is ignored. req_valid outside LOAD is ignored.
//  - Asynchronous reset mid-session: everything returns to its reset values immediately.
//    No partial write is issued.
// STRUCTURE
//  - Shared package rv_pkg: opcode constants (0110011, 0000011, 0100011, 1100011, 1101111),
//    an enc_op_t enum for req_op, and a loader_state_t enum.
//    Add the opcode constants there so the control unit can import the same values.
//  - One sub-module: sync_fifo (WIDTH=32, DEPTH). The encoder function and FSM live in the top.
// TESTING
//  1 start; push ADD rd=3,rs1=1,rs2=2 with imem_ready=1 -> one write, addr 0, data 0x002081B3.
//  2 Push LW x5,8(x2), SW x5,12(x2), BEQ x1,x2,-8, JAL x1,16 -> addrs 0..3, data 0x00812283,
//    0x00512623, 0xFE208CE3, 0x010000EF.
//  3 imem_ready=0 for 6 cycles with 5 pushes -> req_ready drops after 4 pushes, data held;
//    on release all 5 words are written in order.
//  4 ADDR_W=2; push 5 words -> 4 writes, addr_full=1, FULL state, 1 word retained;
//    start -> FIFO flushed, addr 0.
//  5 req_op=6 -> handshake completes, no write, err_op=1; next start clears err_op.
//  6 rst_n low mid-drain with 3 words queued -> imem_we=0 immediately, all outputs at reset values;
//    then finish -> done pulses once after the FIFO empties (separate run).

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the instruction encoder/loader and the opcode-decoding control unit.
package rv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  typedef enum logic [2:0] {
    ENC_ADD = 3'd0,
    ENC_LW  = 3'd1,
    ENC_SW  = 3'd2,
    ENC_BEQ = 3'd3,
    ENC_JAL = 3'd4
  } enc_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FULL  = 2'd3
  } loader_state_t;

  function automatic logic op_is_legal(logic [2:0] op);
    return (op <= 3'd4);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; a push into a full FIFO is only taken alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1'b1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_en_s, pop_en_s;

  assign empty     = (count_q == {(AW+1){1'b0}});
  assign full      = (count_q == CNT_MAX);
  assign rdata     = mem_q[rd_ptr_q];
  assign pop_en_s  = pop && !empty;
  assign push_en_s = push && (!full || pop_en_s);

  // Pointer, occupancy and storage updates.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {(AW+1){1'b0}};
    end else begin
      if (push_en_s) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_en_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_en_s, pop_en_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic RV32I requests into 32-bit words and streams them into instruction memory
// at consecutive word addresses during a start/finish load session.
module instr_encoder_loader
  import rv_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [20:0]       req_imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_op,
  output logic              addr_full
);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_A   = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1'b1);

  function automatic logic [31:0] encode_instr(enc_op_t op, logic [4:0] rd, logic [4:0] rs1,
                                               logic [4:0] rs2, logic [20:0] imm);
    logic [31:0] w;
    case (op)
      ENC_ADD: w = {7'b0000000, rs2, rs1, F3_ADD, rd, OPC_OP};
      ENC_LW:  w = {imm[11:0], rs1, F3_LW, rd, OPC_LOAD};
      ENC_SW:  w = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OPC_STORE};
      ENC_BEQ: w = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OPC_BRANCH};
      ENC_JAL: w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_op_q, err_op_d;
  logic              addr_full_q, addr_full_d;
  logic              done_q, done_d;

  logic        fifo_empty_s, fifo_full_s, op_legal_s;
  logic        push_fire_s, wr_fire_s, hit_last_s;
  logic [31:0] enc_word_s, fifo_head_s;

  assign op_legal_s  = op_is_legal(req_op);
  assign enc_word_s  = encode_instr(enc_op_t'(req_op), req_rd, req_rs1, req_rs2, req_imm);
  assign req_ready   = (state_q == ST_LOAD) && !fifo_full_s;
  assign push_fire_s = req_valid && req_ready && !start;
  // Writes are only offered while a session is open, so FULL retains whatever is still queued.
  assign imem_we     = !fifo_empty_s && ((state_q == ST_LOAD) || (state_q == ST_DRAIN));
  assign wr_fire_s   = imem_we && imem_ready && !start;
  assign hit_last_s  = wr_fire_s && (addr_q == LAST_A);

  assign imem_addr  = addr_q;
  assign imem_wdata = fifo_head_s;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign err_op     = err_op_q;
  assign addr_full  = addr_full_q;

  sync_fifo #(
    .WIDTH(32),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(start),
    .push (push_fire_s && op_legal_s),
    .wdata(enc_word_s),
    .pop  (wr_fire_s),
    .rdata(fifo_head_s),
    .empty(fifo_empty_s),
    .full (fifo_full_s)
  );

  // Session control, write address and sticky flags.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    err_op_d    = err_op_q;
    addr_full_d = addr_full_q;
    done_d      = 1'b0;
    if (start) begin
      state_d     = ST_LOAD;
      addr_d      = BASE_A;
      err_op_d    = 1'b0;
      addr_full_d = 1'b0;
    end else begin
      if (push_fire_s && !op_legal_s) begin
        err_op_d = 1'b1;
      end else begin
        err_op_d = err_op_q;
      end
      if (hit_last_s) begin
        state_d     = ST_FULL;
        addr_full_d = 1'b1;
      end else begin
        if (wr_fire_s) begin
          addr_d = addr_q + ADDR_ONE;
        end else begin
          addr_d = addr_q;
        end
        case (state_q)
          ST_LOAD:  state_d = finish ? ST_DRAIN : ST_LOAD;
          ST_DRAIN: begin
            if (fifo_empty_s) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_DRAIN;
            end
          end
          default:  state_d = state_q;
        endcase
      end
    end
  end

  // Loader state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= BASE_A;
      err_op_q    <= 1'b0;
      addr_full_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      err_op_q    <= err_op_d;
      addr_full_q <= addr_full_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed and randomized bench for instr_encoder_loader against a queue-based session model.
module tb_instr_encoder_loader;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;
  localparam int MAXA   = (1 << ADDR_W) - 1;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [20:0] imm;
  } req_t;

  logic clk, rst_n, start, finish, req_valid, req_ready, imem_we, imem_ready;
  logic busy, done, err_op, addr_full;
  logic [2:0] req_op;
  logic [4:0] req_rd, req_rs1, req_rs2;
  logic [20:0] req_imm;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0] imem_wdata;

  instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rd(req_rd),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err_op(err_op), .addr_full(addr_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  // Model: 0 idle, 1 loading, 2 draining, 3 address space exhausted.
  int phase;
  int exp_addr;
  bit m_err, m_full, m_done, last_acc;
  int done_cnt = 0;
  logic [31:0] q[$];
  logic [31:0] wlog[$];
  int alog[$];
  req_t rq[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(req_t r);
    int unsigned im = 32'(r.imm);
    int unsigned d  = 32'(r.rd);
    int unsigned s1 = 32'(r.rs1);
    int unsigned s2 = 32'(r.rs2);
    case (r.op)
      3'd0: return (s2 << 20) | (s1 << 15) | (d << 7) | 32'h33;
      3'd1: return ((im & 32'hFFF) << 20) | (s1 << 15) | (32'd2 << 12) | (d << 7) | 32'h03;
      3'd2: return (((im >> 5) & 32'h7F) << 25) | (s2 << 20) | (s1 << 15) | (32'd2 << 12)
                 | ((im & 32'h1F) << 7) | 32'h23;
      3'd3: return (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (s2 << 20)
                 | (s1 << 15) | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7) | 32'h63;
      3'd4: return (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                 | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) | (d << 7) | 32'h6F;
      default: return 32'h0;
    endcase
  endfunction

  function automatic req_t mk(int op, int rd, int rs1, int rs2, int imm);
    req_t r;
    r.op = 3'(op); r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.imm = 21'(imm);
    return r;
  endfunction

  function automatic req_t rand_req(bit allow_illegal);
    req_t r;
    if (allow_illegal && ($urandom_range(9) == 0)) r.op = 3'($urandom_range(7, 5));
    else r.op = 3'($urandom_range(4));
    r.rd = 5'($urandom); r.rs1 = 5'($urandom); r.rs2 = 5'($urandom); r.imm = 21'($urandom);
    return r;
  endfunction

  task automatic model_reset();
    q.delete(); exp_addr = 0; m_err = 1'b0; m_full = 1'b0; m_done = 1'b0; phase = 0;
  endtask

  task automatic set_req(req_t r);
    req_op = r.op; req_rd = r.rd; req_rs1 = r.rs1; req_rs2 = r.rs2; req_imm = r.imm;
  endtask

  // Compare this cycle's outputs against the model, then advance the model by one clock.
  task automatic monitor();
    bit ld, exp_we, wr, last;
    int nsize;
    req_t r;
    ld     = (phase == 1);
    exp_we = (q.size() > 0) && (phase == 1 || phase == 2);
    nsize  = q.size();
    chk("req_ready", req_ready, ld && (nsize < DEPTH));
    chk("imem_we", imem_we, exp_we);
    chk("busy", busy, phase != 0);
    chk("done", done, m_done);
    chk("err_op", err_op, m_err);
    chk("addr_full", addr_full, m_full);
    if (exp_we) begin
      chk("imem_wdata", imem_wdata, q[0]);
      chk("imem_addr", imem_addr, exp_addr);
    end
    if (imem_we && imem_ready) begin
      wlog.push_back(imem_wdata);
      alog.push_back(int'(imem_addr));
    end
    if (done) done_cnt++;
    m_done = 1'b0;
    if (start) begin
      q.delete(); exp_addr = 0; m_err = 1'b0; m_full = 1'b0; phase = 1;
    end else begin
      wr   = exp_we && imem_ready;
      last = wr && (exp_addr == MAXA);
      if (wr) begin
        void'(q.pop_front());
        if (!last) exp_addr++;
      end
      if (ld && req_valid && (nsize < DEPTH)) begin
        r.op = req_op; r.rd = req_rd; r.rs1 = req_rs1; r.rs2 = req_rs2; r.imm = req_imm;
        if (req_op <= 3'd4) q.push_back(ref_word(r));
        else m_err = 1'b1;
      end
      if (last) begin
        m_full = 1'b1; phase = 3;
      end else if (phase == 1 && finish) begin
        phase = 2;
      end else if (phase == 2 && nsize == 0) begin
        phase = 0; m_done = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    last_acc = req_valid && req_ready;
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic start_session();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1; tick(); finish = 1'b0;
  endtask

  // Push every request in rq with a random imem_ready duty, until drained or the space fills.
  task automatic drive(int rdy_pct, int budget);
    int idx = 0;
    int n = rq.size();
    bit fin = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (idx < n) begin
        set_req(rq[idx]); req_valid = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      imem_ready = ($urandom_range(99) < rdy_pct);
      tick();
      if (last_acc) idx++;
      if (idx >= n && (q.size() == 0 || phase == 3)) begin
        fin = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
    imem_ready = 1'b1;
    chk("drive_timeout", fin, 1'b1);
    rq.delete();
  endtask

  task automatic wait_idle(int budget);
    for (int c = 0; c < budget; c++) begin
      imem_ready = ($urandom_range(99) < 70);
      tick();
      if (phase == 0) break;
    end
    imem_ready = 1'b1;
    chk("idle_timeout", phase, 0);
    tick(); tick();
  endtask

  task automatic load3_stalled();
    start_session();
    imem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_req(rand_req(1'b0)); req_valid = 1'b1;
      tick();
      chk("load3_accept", last_acc, 1'b1);
    end
    req_valid = 1'b0;
    pulse_finish();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, idx, d0;
    logic [31:0] t2_exp[4];
    t2_exp[0] = 32'h00812283; t2_exp[1] = 32'h00512623;
    t2_exp[2] = 32'hFE208CE3; t2_exp[3] = 32'h010000EF;
    rst_n = 1'b0; start = 1'b0; finish = 1'b0; req_valid = 1'b0; imem_ready = 1'b1;
    set_req(mk(0, 0, 0, 0, 0));
    model_reset();
    #12;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_imem_we", imem_we, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err_op", err_op, 1'b0);
    chk("rst_addr_full", addr_full, 1'b0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_imem_wdata", imem_wdata, 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    tick(); tick();

    // 1: single ADD
    start_session();
    w0 = wlog.size();
    rq.push_back(mk(0, 3, 1, 2, 0));
    drive(100, 20);
    chk("t1_writes", wlog.size() - w0, 1);
    chk("t1_addr", alog[w0], 0);
    chk("t1_data", wlog[w0], 32'h002081B3);

    // 2: LW, SW, BEQ, JAL back to back
    start_session();
    w0 = wlog.size();
    rq.push_back(mk(1, 5, 2, 0, 8));
    rq.push_back(mk(2, 0, 2, 5, 12));
    rq.push_back(mk(3, 0, 1, 2, -8));
    rq.push_back(mk(4, 1, 0, 0, 16));
    drive(100, 40);
    chk("t2_writes", wlog.size() - w0, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_addr%0d", i), alog[w0 + i], i);
      chk($sformatf("t2_data%0d", i), wlog[w0 + i], t2_exp[i]);
    end

    // 3: imem stalled for 6 cycles while 5 pushes are offered
    start_session();
    w0 = wlog.size();
    for (int k = 0; k < 5; k++) rq.push_back(rand_req(1'b0));
    imem_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      set_req(rq[idx]); req_valid = 1'b1;
      tick();
      if (last_acc) idx++;
    end
    chk("t3_accepted", idx, 4);
    chk("t3_ready_low", req_ready, 1'b0);
    chk("t3_no_write", wlog.size() - w0, 0);
    for (int k = 0; k < 4; k++) void'(rq.pop_front());
    drive(100, 30);
    chk("t3_writes", wlog.size() - w0, 5);

    // 4: fill the whole address space plus one word
    start_session();
    w0 = wlog.size();
    for (int k = 0; k <= MAXA + 1; k++) rq.push_back(rand_req(1'b0));
    drive(100, MAXA + 100);
    tick();
    chk("t4_writes", wlog.size() - w0, MAXA + 1);
    chk("t4_addr_full", addr_full, 1'b1);
    chk("t4_we_low", imem_we, 1'b0);
    chk("t4_ready_low", req_ready, 1'b0);
    chk("t4_addr_held", imem_addr, MAXA);
    pulse_finish();
    chk("t4_finish_ignored", busy, 1'b1);
    start_session();
    chk("t4_restart_addr", imem_addr, 0);
    chk("t4_restart_full", addr_full, 1'b0);
    chk("t4_flushed", imem_we, 1'b0);
    pulse_finish();
    wait_idle(20);

    // 5: illegal op
    start_session();
    w0 = wlog.size();
    rq.push_back(mk(6, 1, 2, 3, 4));
    drive(100, 10);
    tick(); tick();
    chk("t5_err_op", err_op, 1'b1);
    chk("t5_no_write", wlog.size() - w0, 0);
    start_session();
    chk("t5_err_cleared", err_op, 1'b0);
    pulse_finish();
    wait_idle(20);

    // 6a: async reset mid-drain
    load3_stalled();
    rst_n = 1'b0;
    #1;
    chk("t6_we", imem_we, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_ready", req_ready, 1'b0);
    chk("t6_addr", imem_addr, 0);
    chk("t6_wdata", imem_wdata, 32'h0);
    chk("t6_done", done, 1'b0);
    model_reset();
    @(posedge clk); #1; rst_n = 1'b1;
    tick();

    // 6b: finish with queued words, done pulses once
    d0 = done_cnt;
    load3_stalled();
    wait_idle(40);
    chk("t6_done_pulses", done_cnt - d0, 1);

    // Randomized sessions
    for (int s = 0; s < 8; s++) begin
      start_session();
      for (int k = 0; k < int'($urandom_range(12, 3)); k++) rq.push_back(rand_req(1'b1));
      drive(70, 400);
      pulse_finish();
      wait_idle(60);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
